// File: rtl/cordic_pkg.sv
// cordic_pkg: state type, gain constant and elaboration-time arctangent table for cordic_vector
package cordic_pkg;
  typedef enum logic [1:0] {IDLE, ROT, DONE} state_t;
  localparam int CORDIC_GAIN_Q16 = 107922;
  localparam int ATAN_MAX = 32;
  typedef logic [ATAN_MAX*32-1:0] atan_tab_t;
  // entry i = round(atan(2^-i) / 2pi * 2^(d_width+guard)), packed 32 bits per entry
  function automatic atan_tab_t build_atan_table(input int d_width, input int guard);
    atan_tab_t tab;
    real t;
    real scale;
    tab = '0;
    t = 1.0;
    scale = 1.0;
    for (int k = 0; k < d_width + guard; k++) scale = scale * 2.0;
    for (int i = 0; i < ATAN_MAX; i++) begin
      tab[i*32 +: 32] = 32'($rtoi($atan(t) / (2.0 * 3.141592653589793) * scale + 0.5));
      t = t / 2.0;
    end
    return tab;
  endfunction
endpackage

// File: rtl/cordic_vec_stage.sv
// cordic_vec_stage: one combinational vectoring micro-rotation, steering y toward zero
module cordic_vec_stage #(
  parameter int XW = 18,
  parameter int ZW = 20,
  parameter int IW = 4
) (
  input  logic signed [XW-1:0] x,
  input  logic signed [XW-1:0] y,
  input  logic        [ZW-1:0] z,
  input  logic        [IW-1:0] i,
  input  logic        [ZW-1:0] atan_i,
  output logic signed [XW-1:0] x_n,
  output logic signed [XW-1:0] y_n,
  output logic        [ZW-1:0] z_n
);
  logic signed [XW-1:0] xs;
  logic signed [XW-1:0] ys;
  logic up;
  always_comb begin
    xs  = x >>> i;
    ys  = y >>> i;
    up  = !y[XW-1];
    x_n = up ? x + ys : x - ys;
    y_n = up ? y - xs : y + xs;
    z_n = up ? z + atan_i : z - atan_i;
  end
endmodule

// File: rtl/cordic_vector.sv
// cordic_vector: iterative vectoring CORDIC returning binary angle atan2(y, x) and gain-scaled magnitude
module cordic_vector
  import cordic_pkg::*;
#(
  parameter int D_WIDTH = 16,
  parameter int ITER    = D_WIDTH,
  parameter int GUARD   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [D_WIDTH-1:0] x_in,
  input  logic [D_WIDTH-1:0] y_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [D_WIDTH-1:0] theta,
  output logic [D_WIDTH+1:0] mag
);
  localparam int XW = D_WIDTH + 2;
  localparam int ZW = D_WIDTH + GUARD;
  localparam int IW = ITER > 1 ? $clog2(ITER) : 1;
  localparam atan_tab_t ATAN = build_atan_table(D_WIDTH, GUARD);
  localparam logic [ZW-1:0] HALF = ZW'(1) << (ZW - 1);
  localparam logic [ZW-1:0] RND  = ZW'(1) << (GUARD - 1);
  state_t state, state_n;
  logic signed [XW-1:0] xr, yr, xn, yn, xe, ye;
  logic [ZW-1:0] zr, zn, zrnd;
  logic [ZW-1:0] atan_rom [ITER];
  logic [IW-1:0] cnt;
  logic zero, neg, last;
  for (genvar k = 0; k < ITER; k++) begin : g_rom
    assign atan_rom[k] = ATAN[k*32 +: ZW];
  end
  assign xe  = XW'($signed(x_in));
  assign ye  = XW'($signed(y_in));
  assign neg = x_in[D_WIDTH-1];
  cordic_vec_stage #(.XW(XW), .ZW(ZW), .IW(IW)) u_stage (
    .x(xr), .y(yr), .z(zr), .i(cnt), .atan_i(atan_rom[cnt]),
    .x_n(xn), .y_n(yn), .z_n(zn)
  );
  always_comb begin
    last      = cnt == IW'(ITER - 1);
    in_ready  = state == IDLE;
    out_valid = state == DONE;
    state_n   = state == IDLE ? (in_valid ? ROT : IDLE)
              : state == ROT  ? (last ? DONE : ROT)
              : (out_ready ? IDLE : DONE);
    zrnd      = zr + RND;
    theta     = out_valid && !zero ? zrnd[ZW-1:GUARD] : '0;
    mag       = out_valid && !zero ? $unsigned(xr) : '0;
  end
  // left half-plane inputs are turned by pi first so the iterations only cover +-pi/2
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      xr    <= '0;
      yr    <= '0;
      zr    <= '0;
      cnt   <= '0;
      zero  <= 1'b0;
    end else begin
      state <= state_n;
      if (in_ready && in_valid) begin
        xr   <= neg ? -xe : xe;
        yr   <= neg ? -ye : ye;
        zr   <= neg ? HALF : '0;
        zero <= x_in == '0 && y_in == '0;
        cnt  <= '0;
      end else if (state == ROT) begin
        xr  <= xn;
        yr  <= yn;
        zr  <= zn;
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule
